// File: rtl/bcd_pkg.sv
// Shared constants, FSM state type and digit helpers for the digit-serial BCD adder/subtractor.
package bcd_pkg;

    localparam int         DIGIT_W = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_FIX = 4'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic digit_bad(input logic [3:0] d);
        return (d > BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit_addsub.sv
// One BCD digit slice: a + b (or a + 9's complement of b) + carry, with decimal correction.
module bcd_digit_addsub
    import bcd_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    input  logic       sub,
    output logic [3:0] s,
    output logic       cout,
    output logic       bad
);

    logic [3:0] b_eff_s;
    logic [4:0] sum_s;

    assign b_eff_s = sub ? (BCD_MAX - b) : b;
    assign sum_s   = {1'b0, a} + {1'b0, b_eff_s} + {4'b0000, cin};
    assign bad     = digit_bad(a) | digit_bad(b);

    // Binary sum above nine wraps into the next decade.
    always_comb begin
        if (sum_s > {1'b0, BCD_MAX}) begin
            s    = sum_s[3:0] + BCD_FIX;
            cout = 1'b1;
        end else begin
            s    = sum_s[3:0];
            cout = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_addsub_serial.sv
// Digit-serial packed-BCD adder/subtractor: one digit per cycle with valid/ready on both sides.
module bcd_addsub_serial
    import bcd_pkg::*;
#(
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  Sub,
    input  logic [4*DIGITS-1:0]   A,
    input  logic [4*DIGITS-1:0]   B,
    input  logic                  Cin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   S,
    output logic                  Cout,
    output logic                  Err
);

    localparam int W  = DIGIT_W * DIGITS;
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d, s_q, s_d;
    logic            sub_q, sub_d, carry_q, carry_d;
    logic            cout_q, cout_d, err_q, err_d, ov_q, ov_d;

    int              idx_s;
    logic [3:0]      dig_s;
    logic            dig_c_s, dig_bad_s, last_s, accept_s;

    assign idx_s    = DIGIT_W * int'(cnt_q);
    assign last_s   = (cnt_q == LAST);
    assign accept_s = (state_q == IDLE) && in_valid;

    bcd_digit_addsub u_digit (
        .a    (a_q[idx_s +: DIGIT_W]),
        .b    (b_q[idx_s +: DIGIT_W]),
        .cin  (carry_q),
        .sub  (sub_q),
        .s    (dig_s),
        .cout (dig_c_s),
        .bad  (dig_bad_s)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = in_valid ? RUN : IDLE;
            RUN:     state_d = last_s ? DONE : RUN;
            DONE:    state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: only IDLE accepts work.
    always_comb begin
        in_ready = (state_q == IDLE);
    end

    // Datapath next-state: capture, per-digit accumulate, final fix-up and handshake.
    always_comb begin
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sub_d   = sub_q;
        carry_d = carry_q;
        s_d     = s_q;
        cout_d  = cout_q;
        err_d   = err_q;
        ov_d    = ov_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    a_d     = A;
                    b_d     = B;
                    sub_d   = Sub;
                    carry_d = Sub ? ~Cin : Cin;
                    s_d     = '0;
                    cout_d  = 1'b0;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            RUN: begin
                s_d[idx_s +: DIGIT_W] = dig_s;
                carry_d = dig_c_s;
                err_d   = err_q | dig_bad_s;
                if (last_s) begin
                    ov_d   = 1'b1;
                    cout_d = sub_q ? ~dig_c_s : dig_c_s;
                    // A malformed operand yields no numeric result at all.
                    if (err_d) begin
                        s_d    = '0;
                        cout_d = 1'b0;
                    end else begin
                        cout_d = sub_q ? ~dig_c_s : dig_c_s;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    ov_d = 1'b0;
                end else begin
                    ov_d = 1'b1;
                end
            end
            default: begin
                ov_d = 1'b0;
            end
        endcase
    end

    // Datapath and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sub_q   <= sub_d;
            carry_q <= carry_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            err_q   <= err_d;
            ov_q    <= ov_d;
        end
    end

    assign S         = s_q;
    assign Cout      = cout_q;
    assign Err       = err_q;
    assign out_valid = ov_q;

endmodule

// File: tb/tb_bcd_addsub_serial.sv
// Self-checking bench for bcd_addsub_serial (DIGITS=3) against an integer-arithmetic reference.
module tb_bcd_addsub_serial;

    localparam int D   = 3;
    localparam int W   = 4 * D;
    localparam int MOD = 1000;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         Sub = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         Cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] S;
    logic         Cout;
    logic         Err;

    int n_vec = 0;
    int n_err = 0;

    bcd_addsub_serial #(.DIGITS(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Sub       (Sub),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .Cout      (Cout),
        .Err       (Err)
    );

    always #5 clk = ~clk;

    function automatic int bval(input logic [W-1:0] v);
        int r = 0;
        for (int i = D - 1; i >= 0; i--) r = r * 10 + int'(v[i*4 +: 4]);
        return r;
    endfunction

    function automatic logic has_bad(input logic [W-1:0] v);
        logic bad = 1'b0;
        for (int i = 0; i < D; i++) if (v[i*4 +: 4] > 4'd9) bad = 1'b1;
        return bad;
    endfunction

    function automatic logic [W-1:0] to_bcd(input int x);
        logic [W-1:0] r = '0;
        int t = x;
        for (int i = 0; i < D; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic model(input logic [W-1:0] a, b, input logic sub, cin,
                         output logic [W-1:0] s, output logic c, e);
        int r;
        if (has_bad(a) || has_bad(b)) begin
            s = '0; c = 1'b0; e = 1'b1;
        end else if (!sub) begin
            r = bval(a) + bval(b) + int'(cin);
            c = (r >= MOD); s = to_bcd(r % MOD); e = 1'b0;
        end else begin
            r = bval(a) - bval(b) - int'(cin);
            c = (r < 0); s = to_bcd((r < 0) ? r + MOD : r); e = 1'b0;
        end
    endtask

    function automatic logic [W-1:0] rand_bcd(input logic allow_bad);
        logic [W-1:0] r;
        for (int i = 0; i < D; i++) begin
            if (allow_bad && ($urandom_range(0, 7) == 0)) r[i*4 +: 4] = 4'($urandom_range(10, 15));
            else r[i*4 +: 4] = 4'($urandom_range(0, 9));
        end
        return r;
    endfunction

    // Drives one operation, measures accept-to-out_valid latency, then accepts the result.
    task automatic do_op(input logic [W-1:0] a, b, input logic sub, cin,
                         output logic [W-1:0] s, output logic c, e, output int lat);
        int guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 50) begin @(negedge clk); guard++; end
        A = a; B = b; Sub = sub; Cin = cin; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin @(posedge clk); lat++; @(negedge clk); end
        s = S; c = Cout; e = Err;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({S, Cout, Err, out_valid, in_ready} !== {12'h000, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL reset: S=%h Cout=%b Err=%b ov=%b ir=%b, want 000 0 0 0 1", S, Cout, Err, out_valid, in_ready);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    typedef struct { logic [W-1:0] a; logic [W-1:0] b; logic sub; logic cin;
                     logic [W-1:0] s; logic c; logic e; } vec_t;

    task automatic test_directed();
        vec_t tbl[7];
        logic [W-1:0] s; logic c, e; int lat;
        tbl[0] = '{12'h999, 12'h001, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0};
        tbl[1] = '{12'h456, 12'h544, 1'b0, 1'b1, 12'h001, 1'b1, 1'b0};
        tbl[2] = '{12'h123, 12'h456, 1'b0, 1'b0, 12'h579, 1'b0, 1'b0};
        tbl[3] = '{12'h100, 12'h001, 1'b1, 1'b0, 12'h099, 1'b0, 1'b0};
        tbl[4] = '{12'h000, 12'h001, 1'b1, 1'b0, 12'h999, 1'b1, 1'b0};
        tbl[5] = '{12'h500, 12'h499, 1'b1, 1'b1, 12'h000, 1'b0, 1'b0};
        tbl[6] = '{12'h1A0, 12'h000, 1'b0, 1'b0, 12'h000, 1'b0, 1'b1};
        for (int i = 0; i < 7; i++) begin
            do_op(tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].cin, s, c, e, lat);
            n_vec++;
            if ({s, c, e} !== {tbl[i].s, tbl[i].c, tbl[i].e}) begin
                n_err++;
                $display("FAIL directed[%0d]: S=%h Cout=%b Err=%b, want S=%h Cout=%b Err=%b",
                         i, s, c, e, tbl[i].s, tbl[i].c, tbl[i].e);
            end
            n_vec++;
            if (lat !== D) begin
                n_err++;
                $display("FAIL latency[%0d]: got %0d cycles, want %0d", i, lat, D);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, s, es; logic sub, cin, c, e, ec, ee; int lat;
        for (int i = 0; i < 200; i++) begin
            a = rand_bcd(1'b1); b = rand_bcd(1'b1);
            sub = 1'($urandom_range(0, 1)); cin = 1'($urandom_range(0, 1));
            model(a, b, sub, cin, es, ec, ee);
            do_op(a, b, sub, cin, s, c, e, lat);
            n_vec++;
            if ({s, c, e, lat == D} !== {es, ec, ee, 1'b1}) begin
                n_err++;
                $display("FAIL random[%0d] %h %s %h cin=%b: S=%h Cout=%b Err=%b lat=%0d, want S=%h Cout=%b Err=%b lat=%0d",
                         i, a, sub ? "-" : "+", b, cin, s, c, e, lat, es, ec, ee, D);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] es; logic ec, ee; int guard = 0;
        model(12'h777, 12'h345, 1'b0, 1'b0, es, ec, ee);
        @(negedge clk);
        A = 12'h777; B = 12'h345; Sub = 1'b0; Cin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && guard < 20) begin @(negedge clk); guard++; end
        for (int k = 0; k < 5; k++) begin
            A = rand_bcd(1'b0); in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            n_vec++;
            if ({S, Cout, Err, in_ready, out_valid} !== {es, ec, ee, 1'b0, 1'b1}) begin
                n_err++;
                $display("FAIL backpressure[%0d]: S=%h Cout=%b Err=%b ir=%b ov=%b, want S=%h Cout=%b Err=%b ir=0 ov=1",
                         k, S, Cout, Err, in_ready, out_valid, es, ec, ee);
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        n_vec++;
        if ({out_valid, in_ready, S} !== {1'b0, 1'b1, es}) begin
            n_err++;
            $display("FAIL release: ov=%b ir=%b S=%h, want ov=0 ir=1 S=%h", out_valid, in_ready, S, es);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [W-1:0] s; logic c, e; int lat;
        @(negedge clk);
        A = 12'h999; B = 12'h999; Sub = 1'b0; Cin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_vec++;
        if ({S, Cout, Err, out_valid, in_ready} !== {12'h000, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL midrun_reset: S=%h Cout=%b Err=%b ov=%b ir=%b, want 000 0 0 0 1", S, Cout, Err, out_valid, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        do_op(12'h005, 12'h005, 1'b0, 1'b0, s, c, e, lat);
        n_vec++;
        if ({s, c, e, lat == D} !== {12'h010, 1'b0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL after_reset: S=%h Cout=%b Err=%b lat=%0d, want S=010 Cout=0 Err=0 lat=%0d", s, c, e, lat, D);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
